// File: rtl/mult_div_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// default latencies and counter sizing.
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // The busy counter is 4 bits, so latencies must fit in 1..15.
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  function automatic bit cycles_legal(input int n);
    return (n >= 1) && (n <= CNT_MAX);
  endfunction

endpackage

// File: rtl/mult_div_calc.sv
// Combinational result generator for the latched operation: 64-bit
// products and 32-bit quotient/remainder, with divide-by-zero flagged.
module mult_div_calc
  import mult_div_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        div_ovf;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Divisor forced non-zero so the dividers never see /0; the result is
  // discarded in that case anyway.
  assign b_safe  = (b == 32'd0) ? 32'd1 : b;
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  assign quo_s = $signed(a) / $signed(b_safe);
  assign rem_s = $signed(a) % $signed(b_safe);
  assign quo_u = a / b_safe;
  assign rem_u = a % b_safe;

  assign div0 = op[1] && (b == 32'd0);

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    case (op_e'(op))
      OP_MULT: begin
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
      end
      OP_MULTU: begin
        hi_res = prod_u[63:32];
        lo_res = prod_u[31:0];
      end
      OP_DIV: begin
        if (div_ovf) begin
          hi_res = 32'd0;
          lo_res = 32'h8000_0000;
        end else begin
          hi_res = rem_s;
          lo_res = quo_s;
        end
      end
      OP_DIVU: begin
        hi_res = rem_u;
        lo_res = quo_u;
      end
      default: begin
        hi_res = '0;
        lo_res = '0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div.sv
// Multi-cycle multiply/divide unit with HI/LO registers. A down-counter
// models the operation latency; results land on the 1->0 transition.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  if (!cycles_legal(MULT_CYCLES)) begin : g_bad_mult_cycles
    $error("mult_div: MULT_CYCLES must be in 1..15");
  end
  if (!cycles_legal(DIV_CYCLES)) begin : g_bad_div_cycles
    $error("mult_div: DIV_CYCLES must be in 1..15");
  end

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic [31:0]      hi_res;
  logic [31:0]      lo_res;
  logic             div0;
  logic             launch;
  logic             finish;
  logic             move_to;

  mult_div_calc u_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .div0   (div0)
  );

  assign busy      = (cnt != '0);
  assign stall_req = busy | start;
  assign launch    = start & ~busy;
  assign finish    = (cnt == CNT_W'(1));
  // mthi/mtlo only when the unit is idle and not being launched this cycle.
  assign move_to   = hilo_we & ~busy & ~start;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (launch) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
        cnt  <= op[1] ? DIV_LOAD : MULT_LOAD;
      end else if (busy) begin
        cnt <= cnt - 1'b1;
      end

      if (finish) begin
        if (!div0) begin
          hi_q <= hi_res;
          lo_q <= lo_res;
        end
      end else if (move_to) begin
        if (hilo_sel) hi_q <= a;
        else          lo_q <= a;
      end
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Randomized self-checking bench for mult_div against an arithmetic
// reference model of HI/LO and the busy window.
module tb_mult_div;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_we;
  logic        hilo_sel;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mult_div #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .hilo_we   (hilo_we),
    .hilo_sel  (hilo_sel),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS HI/LO semantics computed with 64-bit arithmetic.
  task automatic model_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    longint          sp;
    longint unsigned up;
    longint          sq;
    longint          sr;
    case (op_i)
      2'b00: begin
        sp = longint'($signed(a_i)) * longint'($signed(b_i));
        hi_m = sp[63:32];
        lo_m = sp[31:0];
      end
      2'b01: begin
        up = longint'({32'b0, a_i}) * longint'({32'b0, b_i});
        hi_m = up[63:32];
        lo_m = up[31:0];
      end
      2'b10: begin
        if (b_i != 0) begin
          sq = longint'($signed(a_i)) / longint'($signed(b_i));
          sr = longint'($signed(a_i)) % longint'($signed(b_i));
          lo_m = sq[31:0];
          hi_m = sr[31:0];
        end
      end
      default: begin
        if (b_i != 0) begin
          lo_m = a_i / b_i;
          hi_m = a_i % b_i;
        end
      end
    endcase
  endtask

  task automatic move_to(input bit sel, input logic [31:0] val);
    hilo_we = 1'b1; hilo_sel = sel; a = val;
    tick();
    hilo_we = 1'b0;
    if (sel) hi_m = val; else lo_m = val;
    hilo_sel = 1'b1;
    #1 check("rdata_hi", rdata, hi_m);
    hilo_sel = 1'b0;
    #1 check("rdata_lo", rdata, lo_m);
  endtask

  // Launch one op, check the busy window cycle by cycle, then the result.
  // collide: second start + hilo_we at busy cycle 2, hilo_we with launch.
  task automatic do_op(input logic [1:0] op_i, input logic [31:0] a_i,
                       input logic [31:0] b_i, input bit collide);
    int n;
    n = op_i[1] ? DIV_N : MULT_N;
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    hilo_we = collide; hilo_sel = 1'b0;
    #1 check("stall_on_start", stall_req, 1'b1);
    tick();
    start = 1'b0; hilo_we = 1'b0;
    for (int i = 1; i <= n; i++) begin
      if (collide && i == 2) begin
        start = 1'b1; hilo_we = 1'b1; hilo_sel = 1'b1;
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0; hilo_we = 1'b0;
      end
      #1;
      check("busy_window", busy, 1'b1);
      check("stall_busy", stall_req, 1'b1);
      check("hi_hold", hi, hi_m);
      check("lo_hold", lo, lo_m);
      tick();
    end
    start = 1'b0; hilo_we = 1'b0;
    model_op(op_i, a_i, b_i);
    #1;
    check("busy_done", busy, 1'b0);
    check("stall_idle", stall_req, 1'b0);
    check($sformatf("hi_op%0d", op_i), hi, hi_m);
    check($sformatf("lo_op%0d", op_i), lo, lo_m);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hilo_we = 1'b0; hilo_sel = 1'b0;
    hi_m = '0; lo_m = '0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    rst = 1'b0;
    #1 check("rst_stall", stall_req, 1'b0);

    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_dir_hi", hi, 32'hFFFF_FFFF);
    check("mult_dir_lo", lo, 32'hFFFF_FFFA);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_dir_hi", hi, 32'hFFFF_FFFE);
    check("multu_dir_lo", lo, 32'h0000_0001);

    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_dir_lo", lo, 32'hFFFF_FFFD);
    check("div_dir_hi", hi, 32'hFFFF_FFFF);

    move_to(1'b1, 32'h11);
    move_to(1'b0, 32'h22);
    do_op(2'b11, 32'd1234, 32'd0, 1'b0);
    check("divu0_hi", hi, 32'h11);
    check("divu0_lo", lo, 32'h22);

    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0);

    do_op(2'b00, 32'd123456, 32'hFFFF_FF00, 1'b1);
    do_op(2'b11, 32'd1000, 32'd7, 1'b1);

    for (int k = 0; k < 24; k++) begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      int          pick;
      rop  = 2'($urandom_range(0, 3));
      ra   = $urandom;
      rb   = $urandom;
      pick = $urandom_range(0, 7);
      if (pick == 0) rb = 32'd0;
      else if (pick == 1) rb = 32'($urandom_range(1, 20));
      else if (pick == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ((k % 6) == 5) move_to(k[0], $urandom);
      do_op(rop, ra, rb, (pick == 3));
    end

    // rst overrides start and hilo_we in the same cycle.
    move_to(1'b1, 32'hA5A5_0001);
    rst = 1'b1; start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9; hilo_we = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; hilo_we = 1'b0;
    hi_m = '0; lo_m = '0;
    #1;
    check("rst_ovr_busy", busy, 1'b0);
    check("rst_ovr_hi", hi, 32'h0);
    check("rst_ovr_lo", lo, 32'h0);

    // rst at busy cycle 3 of a div aborts with no HI/LO write.
    move_to(1'b1, 32'h3333);
    move_to(1'b0, 32'h4444);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    tick(); tick();
    #1 check("abort_busy3", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    for (int i = 0; i < DIV_N + 2; i++) tick();
    check("abort_late_hi", hi, 32'h0);
    check("abort_late_lo", lo, 32'h0);
    check("abort_late_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  launch the operation selected by op. Driven from ID/EX MultDivStart_out.
REQ-006 SHALL have port op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu. Driven from MultDivOp_out.
REQ-007 SHALL have port a  input  32  operand rs, already forwarded.
REQ-008 SHALL have port b  input  32  operand rt, already forwarded.
REQ-009 SHALL have port hilo_we  input  1  write a into HI or LO (mthi/mtlo). Driven from HiLoWe_out.
REQ-010 SHALL have port hilo_sel  input  1  1 selects HI, 0 selects LO, for both write and rdata. Driven from HiLo_out.
REQ-011 SHALL have port busy  output  1  an operation is in progress.
REQ-012 SHALL have port stall_req  output  1  combinational busy | start, for the hazard unit.
REQ-013 SHALL have port hi  output  32  HI register.
REQ-014 SHALL have port lo  output  32  LO register.
REQ-015 SHALL have port rdata  output  32  combinational: hi if hilo_sel else lo, for mfhi/mflo.

Function
REQ-016 SHALL accept start only when busy=0.
- On acceptance, latch op, a and b.
- Load the cycle counter with MULT_CYCLES (op[1]=0) or DIV_CYCLES (op[1]=1).
REQ-017 SHALL ignore start while busy=1: no relaunch, and latched operands are unchanged.
REQ-018 SHALL drive busy=1 exactly when counter != 0, giving N busy cycles after the accepting edge.
REQ-019 SHALL decrement the counter by 1 on each edge while it is non-zero.
REQ-020 SHALL write HI/LO on the edge where the counter goes from 1 to 0. The new values are visible in the first cycle with busy=0.
REQ-021 SHALL compute mult as the signed 64-bit product of the latched operands: HI = product[63:32], LO = product[31:0].
REQ-022 SHALL compute multu as the unsigned 64-bit product, split into HI/LO the same way.
REQ-023 SHALL compute div signed: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
REQ-024 SHALL compute divu unsigned: LO = quotient, HI = remainder.
REQ-025 SHALL, for the divide-by-zero case (b=0 on div/divu), still run DIV_CYCLES and leave HI and LO unchanged.
REQ-026 SHALL, for signed overflow 0x80000000 / 0xFFFFFFFF, write LO=0x80000000 and HI=0.
REQ-027 SHALL, when hilo_we=1 and busy=0 and start=0, write a into the register chosen by hilo_sel on that edge.
REQ-028 SHALL ignore hilo_we when busy=1 or start=1 in the same cycle; start has priority.
REQ-029 SHALL keep HI/LO unchanged in all other cycles.

Reset
REQ-030 SHALL, on rst=1 at a posedge, clear counter, hi, lo and all latched operands to 0, so that busy=0 the next cycle.
REQ-031 SHALL let rst override start and hilo_we in the same cycle.
REQ-032 SHALL, on rst mid-operation, abort the operation with no HI/LO write.
REQ-033 SHALL give stall_req no reset term; it follows busy and start combinationally.

Structure
REQ-034 SHALL place the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the default cycle counts in shared package mult_div_pkg.
REQ-035 SHALL place the combinational result computation in one sub-module, mult_div_calc: op, a, b in; hi_res, lo_res, div0 out.
REQ-036 SHALL size the counter as 4 bits and register the latency parameter legal range 1..15.

Verification
REQ-037 SHALL cover mult: op=00, a=0xFFFFFFFE (-2), b=3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-038 SHALL cover multu: op=01, a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
REQ-039 SHALL cover div: op=10, a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-040 SHALL cover divu by zero: HI=0x11, LO=0x22 preloaded via hilo_we, then op=11, b=0 -> 10 busy cycles, HI=0x11, LO=0x22.
REQ-041 SHALL cover collisions: start, then a second start plus hilo_we at busy cycle 2 -> both ignored; result is from the first operands only.
REQ-042 SHALL cover rst at busy cycle 3 of div -> next cycle busy=0, HI=LO=0, and no later write.
